// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate-extension pipeline for the decode stage.
// Optional output-handshake statistics are built when IMM_EXT_STATS_EN is defined.
module imm_extend_pipe #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [15:0]      stat_count,
  output logic [15:0]      stat_neg
`endif
);

  localparam int PAD_W = OUT_W - IN_W;

  // Extension rules keyed by mode; mode 2'b10 reuses the sign-extended value.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0] mode);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] res;
    sext = {{PAD_W{imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   res = {{PAD_W{1'b0}}, imm};
      2'b01:   res = sext;
      2'b10:   res = sext << SHIFT;
      2'b11:   res = {imm, {PAD_W{1'b0}}};
      default: res = {OUT_W{1'b0}};
    endcase
    return res;
  endfunction

  logic            s1_valid_r;
  logic [IN_W-1:0] s1_imm_r;
  logic [1:0]      s1_mode_r;
  logic            s2_valid_r;
  logic            s2_adv_s;
  logic            s1_load_s;
  logic [OUT_W-1:0] ext_s;

  // Handshake decode; in_ready depends combinationally on out_ready.
  always_comb begin
    s2_adv_s  = s1_valid_r & (~s2_valid_r | out_ready);
    in_ready  = ~s1_valid_r | s2_adv_s;
    s1_load_s = in_valid & in_ready;
    ext_s     = extend(s1_imm_r, s1_mode_r);
  end

  // Stage 1: capture the raw field, or empty when its item moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_imm_r   <= {IN_W{1'b0}};
      s1_mode_r  <= 2'b00;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_imm_r   <= in_imm;
      s1_mode_r  <= in_mode;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: registered result; data holds while stalled or after draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      out_data   <= {OUT_W{1'b0}};
      out_neg    <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= 1'b1;
      out_data   <= ext_s;
      out_neg    <= ext_s[OUT_W-1];
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign out_valid = s2_valid_r;

`ifdef IMM_EXT_STATS_EN
  // Handshake counters, free-running with natural 16-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count <= 16'h0000;
      stat_neg   <= 16'h0000;
    end else if (s2_valid_r && out_ready) begin
      stat_count <= stat_count + 16'h0001;
      stat_neg   <= out_neg ? stat_neg + 16'h0001 : stat_neg;
    end else begin
      stat_count <= stat_count;
      stat_neg   <= stat_neg;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (IN_W=6, OUT_W=32, SHIFT=2).
module tb_imm_extend_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_neg;
`ifdef IMM_EXT_STATS_EN
  logic [15:0] stat_count;
  logic [15:0] stat_neg;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  imm_extend_pipe #(.IN_W(6), .OUT_W(32), .SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
`ifdef IMM_EXT_STATS_EN
    , .stat_count(stat_count), .stat_neg(stat_neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated item with out_ready high; result visible two edges later.
  task automatic send_one(input logic [5:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp, input logic neg);
    @(negedge clk);
    in_valid = 1'b1; in_imm = imm; in_mode = mode; out_ready = 1'b1;
    check("ready_idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_not_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("ext_valid", {31'd0, out_valid}, 32'd1);
    check("ext_data", out_data, exp);
    check("ext_neg", {31'd0, out_neg}, {31'd0, neg});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_imm = 6'h00; in_mode = 2'b00; out_ready = 1'b1;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'h0);
    check("rst_neg", {31'd0, out_neg}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    send_one(6'h20, 2'b01, 32'hFFFFFFE0, 1'b1);
    send_one(6'h20, 2'b00, 32'h00000020, 1'b0);
    send_one(6'h3F, 2'b10, 32'hFFFFFFFC, 1'b1);
    send_one(6'h01, 2'b11, 32'h04000000, 1'b0);
    send_one(6'h1F, 2'b01, 32'h0000001F, 1'b0);
    send_one(6'h1F, 2'b10, 32'h0000007C, 1'b0);
    send_one(6'h3F, 2'b11, 32'hFC000000, 1'b1);

    // Back-pressure: 1 and 2 fill the pipe, 3 must wait.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 6'd1; in_mode = 2'b00;
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_imm = 6'd2;
    check("bp_rdy2", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_imm = 6'd3;
    check("bp_rdy3", {31'd0, in_ready}, 32'd0);
    check("bp_out1", out_data, 32'd1);
    @(negedge clk);
    check("bp_hold", out_data, 32'd1);
    check("bp_hold_v", {31'd0, out_valid}, 32'd1);
    check("bp_rdy3b", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1 check("bp_rdy_comb", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out2", out_data, 32'd2);
    @(negedge clk);
    check("bp_out3", out_data, 32'd3);
    check("bp_out3_v", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming: one result per cycle, in order.
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        check("strm_valid", {31'd0, out_valid}, 32'd1);
        check("strm_data", out_data, 32'(cyc - 2 + 10));
      end
      if (cyc < 8) begin
        check("strm_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_imm = 6'(cyc + 10); in_mode = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("strm_end", {31'd0, out_valid}, 32'd0);

    // Reset with two items in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 6'h30; in_mode = 2'b01;
    @(negedge clk); in_imm = 6'h31;
    @(negedge clk); in_valid = 1'b0;
    check("fl_full", out_data, 32'hFFFFFFF0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", out_data, 32'h0);
    check("arst_neg", {31'd0, out_neg}, 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_stale", {31'd0, out_valid}, 32'd0);
    end

`ifdef IMM_EXT_STATS_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("st_rst", {16'd0, stat_count}, 32'd0);
    send_one(6'h20, 2'b01, 32'hFFFFFFE0, 1'b1);
    send_one(6'h20, 2'b00, 32'h00000020, 1'b0);
    send_one(6'h3F, 2'b10, 32'hFFFFFFFC, 1'b1);
    send_one(6'h01, 2'b11, 32'h04000000, 1'b0);
    send_one(6'h3F, 2'b11, 32'hFC000000, 1'b1);
    @(negedge clk);
    check("st_count5", {16'd0, stat_count}, 32'd5);
    check("st_neg3", {16'd0, stat_neg}, 32'd3);
    // 65530 more back-to-back handshakes bring the count to 16'hFFFF.
    in_valid = 1'b1; in_imm = 6'h00; in_mode = 2'b00;
    for (int n = 0; n < 65530; n++) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("st_ffff", {16'd0, stat_count}, 32'h0000FFFF);
    send_one(6'h01, 2'b00, 32'h00000001, 1'b0);
    @(negedge clk);
    check("st_wrap", {16'd0, stat_count}, 32'd0);
    check("st_neg_kept", {16'd0, stat_neg}, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
